// File: rtl/menu_input_decoder.sv
// Conditions raw menu buttons and the left mouse button into one-hot,
// single-cycle command pulses, with fixed-priority arbitration and direction auto-repeat.
module menu_input_decoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_right,
    input  logic btn_left,
    input  logic mouse_left_raw,
    output logic top,
    output logic bottom,
    output logic right,
    output logic left,
    output logic mouse_left
);
    localparam int NCH  = 5;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] RD_LIM = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] RP_LIM = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    // Channel index doubles as the bit position in every per-channel vector.
    localparam logic [2:0] CH_MOUSE = 3'd0;
    localparam logic [2:0] CH_DOWN  = 3'd1;
    localparam logic [2:0] CH_UP    = 3'd2;
    localparam logic [2:0] CH_RIGHT = 3'd3;
    localparam logic [2:0] CH_LEFT  = 3'd4;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [NCH-1:0] stb_q, stb_d, prev_q, prev_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] press;

    state_t         state_q, state_d;
    logic [2:0]     active_q, active_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [NCH-1:0] out_q, out_d;
    logic           dir_press;
    logic [2:0]     dir_win;
    logic           repeat_fire;

    assign raw    = {btn_left, btn_right, btn_up, btn_down, mouse_left_raw};
    assign s1_d   = raw;
    assign s2_d   = s1_q;
    assign prev_d = stb_q;
    assign press  = stb_q & ~prev_q;

    always_comb begin
        stb_d = stb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stb_q[i]) begin
                if (cnt_q[i] == DB_LIM) begin
                    stb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        timer_d     = timer_q;
        out_d       = '0;
        dir_press   = 1'b0;
        dir_win     = active_q;
        repeat_fire = 1'b0;

        if (press[CH_DOWN]) begin
            dir_press = 1'b1;
            dir_win   = CH_DOWN;
        end else if (press[CH_UP]) begin
            dir_press = 1'b1;
            dir_win   = CH_UP;
        end else if (press[CH_RIGHT]) begin
            dir_press = 1'b1;
            dir_win   = CH_RIGHT;
        end else if (press[CH_LEFT]) begin
            dir_press = 1'b1;
            dir_win   = CH_LEFT;
        end

        if (press[CH_MOUSE]) begin
            out_d[CH_MOUSE] = 1'b1;
        end

        // A mouse press wins the cycle but leaves the repeat machinery running.
        if (dir_press && !press[CH_MOUSE]) begin
            out_d[dir_win] = 1'b1;
            active_d       = dir_win;
            timer_d        = T_ONE;
            state_d        = DELAY;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                end
                DELAY: begin
                    if (!stb_q[active_q]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_q == RD_LIM) begin
                        repeat_fire = 1'b1;
                        timer_d     = T_ONE;
                        state_d     = REPEAT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!stb_q[active_q]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_q == RP_LIM) begin
                        repeat_fire = 1'b1;
                        timer_d     = T_ONE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
            if (repeat_fire && !press[CH_MOUSE]) begin
                out_d[active_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            stb_q  <= '0;
            prev_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            state_q  <= IDLE;
            active_q <= '0;
            timer_q  <= '0;
            out_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stb_q    <= stb_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            out_q    <= out_d;
        end
    end

    assign mouse_left = out_q[CH_MOUSE];
    assign bottom     = out_q[CH_DOWN];
    assign top        = out_q[CH_UP];
    assign right      = out_q[CH_RIGHT];
    assign left       = out_q[CH_LEFT];

endmodule

// File: tb/tb_menu_input_decoder.sv
// Scoreboard bench for menu_input_decoder: expected pulses (cycle, one-hot outputs)
// are queued with the stimulus and matched against pulses captured from the DUT.
module tb_menu_input_decoder;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    localparam logic [4:0] M = 5'b00001;
    localparam logic [4:0] B = 5'b00010;
    localparam logic [4:0] T = 5'b00100;
    localparam logic [4:0] R = 5'b01000;
    localparam logic [4:0] L = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] outs;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
    logic mouse_left_raw = 1'b0;
    logic top, bottom, right, left, mouse_left;
    logic [4:0] outs;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_fail = 0;

    menu_input_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_right     (btn_right),
        .btn_left      (btn_left),
        .mouse_left_raw(mouse_left_raw),
        .top           (top),
        .bottom        (bottom),
        .right         (right),
        .left          (left),
        .mouse_left    (mouse_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {left, right, top, bottom, mouse_left};

    // Every nonzero output cycle is captured; cyc names the edge that registered it.
    always @(negedge clk) begin
        if (outs != 5'b0) obs_q.push_back(ev_t'{cyc, outs});
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [4:0] o);
        exp_q.push_back(ev_t'{c, o});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_right = 1'b0; btn_left = 1'b0;
        mouse_left_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        ev_t e, o;
        int  k;
        @(negedge clk);
        rst = 1'b0;
        btn_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 5'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: got %b, expected 00000", outs);
            end
        end
        k = cyc;
        rst = 1'b1;
        push_exp(k + 8, T);
        goto(k + 8);
        btn_up = 1'b0;
        goto(k + 30);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL reset_pulse: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL reset_pulse: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL reset_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    task automatic test_bounce();
        ev_t e, o;
        int  k;
        logic [4:0] pattern;
        do_reset();
        pattern = 5'b10101;
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            btn_down = pattern[i];
            if (i < 4) @(negedge clk);
        end
        push_exp(k + 12, B);
        goto(k + 12);
        btn_down = 1'b0;
        goto(k + 40);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL bounce: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL bounce: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL bounce: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    task automatic test_auto_repeat();
        ev_t e, o;
        int  p;
        do_reset();
        p = cyc + 8;
        btn_right = 1'b1;
        push_exp(p, R);
        for (int n = RD; n <= 40; n += RP) push_exp(p + n, R);
        goto(p + 35);
        btn_right = 1'b0;
        goto(p + 70);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL auto_repeat: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL auto_repeat: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL auto_repeat: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        int  p;
        do_reset();
        p = cyc + 8;
        btn_up = 1'b1;
        btn_down = 1'b1;
        push_exp(p, B);
        push_exp(p + RD, B);
        push_exp(p + RD + RP, B);
        goto(p + 12);
        btn_down = 1'b0;
        goto(p + 50);
        btn_up = 1'b0;
        goto(p + 70);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL simultaneous: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL simultaneous: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL simultaneous: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    task automatic test_mouse_during_hold();
        ev_t e, o;
        int  p;
        do_reset();
        p = cyc + 8;
        btn_left = 1'b1;
        push_exp(p, L);
        push_exp(p + 10, L);
        push_exp(p + 15, L);
        push_exp(p + 17, M);
        push_exp(p + 20, L);
        push_exp(p + 25, L);
        push_exp(p + 30, L);
        goto(p + 9);
        mouse_left_raw = 1'b1;
        goto(p + 17);
        mouse_left_raw = 1'b0;
        goto(p + 26);
        btn_left = 1'b0;
        goto(p + 60);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL mouse_hold: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL mouse_hold: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL mouse_hold: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    task automatic test_mid_hold_reset();
        ev_t e, o;
        int  p, j;
        do_reset();
        p = cyc + 8;
        btn_up = 1'b1;
        push_exp(p, T);
        goto(p + 9);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 5'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_outputs: got %b, expected 00000", outs);
            end
        end
        j = cyc;
        rst = 1'b1;
        push_exp(j + 8, T);
        goto(j + 8);
        btn_up = 1'b0;
        goto(j + 30);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); n_fail++;
                $display("[TB] FAIL mid_reset: got no pulse, expected %b at cycle %0d", e.outs, e.cyc);
            end else if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); n_fail++;
                $display("[TB] FAIL mid_reset: got %b at cycle %0d, expected no pulse", o.outs, o.cyc);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.outs !== e.outs) begin
                    n_fail++;
                    $display("[TB] FAIL mid_reset: got %b at cycle %0d, expected %b at cycle %0d",
                             o.outs, o.cyc, e.outs, e.cyc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_mouse_during_hold();
        test_mid_hold_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
